// File: rtl/dpb_port_arbiter_pkg.sv
// Shared types for the dual-port RAM port arbiter.
//   arb_state_e : access sequencer states (IDLE -> ISSUE -> CAPTURE -> ACK)
//   gnt_e       : which requester owns the current access (A = CPU bus, B = DMA/PPU)
package dpb_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2,
        StAck     = 2'd3
    } arb_state_e;

    typedef enum logic {
        GntA = 1'b0,
        GntB = 1'b1
    } gnt_e;

endpackage

// File: rtl/dpb_port_arbiter_if.sv
// Requester-side handshake bundle for dpb_port_arbiter.
//   x_req/x_we/x_addr/x_wdata : access request from requester x (held until x_ack)
//   x_rdata/x_ack              : read data and one-cycle completion pulse back to requester x
//   master : requester side (drives requests)
//   slave  : arbiter side (drives rdata/ack)
interface dpb_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_ack;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_ack;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ack,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ack
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ack,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ack
    );

endinterface

// File: rtl/dpb_rr_pick2.sv
// Combinational two-way grant picker.
//   req_a, req_b : eligible requests
//   last         : previous grant (round-robin history)
//   mode         : 0 = round robin, 1 = fixed priority with A winning ties
//   gnt_valid    : at least one request present
//   gnt          : chosen requester
module dpb_rr_pick2
    import dpb_port_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  gnt_e last,
    input  logic mode,
    output logic gnt_valid,
    output gnt_e gnt
);

    always_comb begin
        gnt_valid = req_a | req_b;
        gnt       = GntA;
        if (req_a && req_b) begin
            // Tie: fixed mode always favours A; round robin favours whoever did not go last.
            gnt = (mode || (last == GntB)) ? GntA : GntB;
        end else if (req_b) begin
            gnt = GntB;
        end
    end

endmodule

// File: rtl/dpb_port_arbiter.sv
// Shares one synchronous RAM port between requesters A and B.
// Every access runs IDLE/ACK -> ISSUE -> CAPTURE -> ACK; the ack is a one-cycle pulse.
//   clk, rst_n : clock (shared with the RAM port) and async active-low reset
//   bus        : requester handshakes (slave side)
//   mem_we/mem_addr/mem_din : registered drive of the RAM port
//   mem_dout   : RAM read data, one cycle after the RAM samples mem_*
//   busy       : high whenever an access is in progress
module dpb_port_arbiter
    import dpb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpb_port_arbiter_if.slave     bus,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy
);

    localparam bit FixedPrio = (PRIORITY_MODE != 0);

    arb_state_e            state_q, state_d;
    gnt_e                  gnt_q, gnt_d;
    gnt_e                  last_q, last_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;

    logic elig_a, elig_b;
    logic pick_valid;
    gnt_e pick_gnt;

    // The requester being acked this cycle may still show req high; that is the tail of the
    // finished access, not a new one.
    assign elig_a = bus.a_req && !((state_q == StAck) && (gnt_q == GntA));
    assign elig_b = bus.b_req && !((state_q == StAck) && (gnt_q == GntB));

    dpb_rr_pick2 u_pick (
        .req_a     (elig_a),
        .req_b     (elig_b),
        .last      (last_q),
        .mode      (FixedPrio),
        .gnt_valid (pick_valid),
        .gnt       (pick_gnt)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        mem_we_d   = 1'b0;      // write strobe lasts only the ISSUE cycle
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;

        unique case (state_q)
            StIdle, StAck: begin
                if (pick_valid) begin
                    state_d = StIssue;
                    gnt_d   = pick_gnt;
                    last_d  = pick_gnt;
                    if (pick_gnt == GntA) begin
                        mem_we_d   = bus.a_we;
                        mem_addr_d = bus.a_addr;
                        mem_din_d  = bus.a_wdata;
                    end else begin
                        mem_we_d   = bus.b_we;
                        mem_addr_d = bus.b_addr;
                        mem_din_d  = bus.b_wdata;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                state_d = StAck;
                if (gnt_q == GntA) begin
                    a_rdata_d = mem_dout;
                    a_ack_d   = 1'b1;
                end else begin
                    b_rdata_d = mem_dout;
                    b_ack_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= GntA;
            last_q     <= GntB;     // so A wins the first tie
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign busy        = (state_q != StIdle);
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;

endmodule
